// File: rtl/hx8352_bus_responder_if.sv
// HX8352 8080-style bus plus decoded-event handshake, shared by the responder
// (slave) and whatever drives the panel side and consumes events (master).
interface hx8352_bus_responder_if;
    logic        lcd_cs;
    logic        lcd_rs;
    logic        lcd_wr;
    logic        lcd_rd;
    logic [15:0] lcd_data_in;
    logic [15:0] lcd_data_out;
    logic        lcd_data_oe;
    logic        ev_valid;
    logic        ev_ready;
    logic        ev_is_data;
    logic [7:0]  ev_index;
    logic [15:0] ev_data;

    modport master (
        output lcd_cs, lcd_rs, lcd_wr, lcd_rd, lcd_data_in, ev_ready,
        input  lcd_data_out, lcd_data_oe, ev_valid, ev_is_data, ev_index, ev_data
    );

    modport slave (
        input  lcd_cs, lcd_rs, lcd_wr, lcd_rd, lcd_data_in, ev_ready,
        output lcd_data_out, lcd_data_oe, ev_valid, ev_is_data, ev_index, ev_data
    );
endinterface

// File: rtl/hx8352_bus_responder.sv
// HX8352 bus target emulation: decodes index/data writes, 256x16 register file,
// GRAM pixel counting and a one-deep event port. Read data is driven only when
// HX8352_RESP_READBACK_EN is defined.
module hx8352_bus_responder #(
    parameter int          SYNC_STAGES  = 2,
    parameter logic [7:0]  GRAM_INDEX   = 8'h22,
    parameter int          FRAME_PIXELS = 96000,
    parameter logic [15:0] STATUS_WORD  = 16'h0052
) (
    input  logic                  clk,
    input  logic                  rst,
    hx8352_bus_responder_if.slave bus,
    output logic [16:0]           pixel_count,
    output logic                  frame_done,
    output logic                  err_overflow,
    output logic                  err_proto
);

`ifdef HX8352_RESP_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, WRITE, READ, ERROR} state_t;

    logic [SYNC_STAGES-1:0] cs_p, rs_p, wr_p, rd_p;
    logic [15:0]            data_p [SYNC_STAGES+1];
    logic                   cs_s, rs_s, wr_s, rd_s;
    logic [15:0]            data_s;

    state_t      state_q, state_d;
    logic        commit, proto_hit, read_active;
    logic [7:0]  index_q;
    logic [15:0] regfile [256];
    logic [15:0] read_word;

    logic        ev_valid_q, ev_is_data_q;
    logic [7:0]  ev_index_q;
    logic [15:0] ev_data_q;
    logic        oe_q;
    logic [15:0] dout_q;

    // Control synchronizers idle at the bus-inactive levels.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_p <= '1;
            rs_p <= '0;
            wr_p <= '1;
            rd_p <= '1;
        end else begin
            cs_p <= {cs_p[SYNC_STAGES-2:0], bus.lcd_cs};
            rs_p <= {rs_p[SYNC_STAGES-2:0], bus.lcd_rs};
            wr_p <= {wr_p[SYNC_STAGES-2:0], bus.lcd_wr};
            rd_p <= {rd_p[SYNC_STAGES-2:0], bus.lcd_rd};
        end
    end

    // One extra data stage so the committed word is the one sampled before lcd_wr rose.
    always_ff @(posedge clk) begin
        data_p[0] <= bus.lcd_data_in;
        for (int i = 1; i <= SYNC_STAGES; i++) begin
            data_p[i] <= data_p[i-1];
        end
    end

    assign cs_s   = cs_p[SYNC_STAGES-1];
    assign rs_s   = rs_p[SYNC_STAGES-1];
    assign wr_s   = wr_p[SYNC_STAGES-1];
    assign rd_s   = rd_p[SYNC_STAGES-1];
    assign data_s = data_p[SYNC_STAGES];

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        commit    = 1'b0;
        proto_hit = !cs_s && !wr_s && !rd_s;
        if (proto_hit) begin
            state_d = ERROR;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!cs_s && !wr_s)      state_d = WRITE;
                    else if (!cs_s && !rd_s) state_d = READ;
                end
                WRITE: begin
                    if (cs_s) begin
                        state_d = IDLE;
                    end else if (wr_s) begin
                        state_d = IDLE;
                        commit  = 1'b1;
                    end
                end
                READ: begin
                    if (cs_s || rd_s) state_d = IDLE;
                end
                ERROR: begin
                    if (wr_s && rd_s) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (commit && rs_s && (index_q != GRAM_INDEX)) regfile[index_q] <= data_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            index_q      <= '0;
            pixel_count  <= '0;
            frame_done   <= 1'b0;
            err_overflow <= 1'b0;
            err_proto    <= 1'b0;
            ev_valid_q   <= 1'b0;
            ev_is_data_q <= 1'b0;
            ev_index_q   <= '0;
            ev_data_q    <= '0;
        end else begin
            frame_done <= 1'b0;
            if (proto_hit) err_proto <= 1'b1;

            if (commit) begin
                if (!rs_s) begin
                    index_q <= data_s[7:0];
                    if (data_s[7:0] == GRAM_INDEX) pixel_count <= '0;
                end else if (index_q == GRAM_INDEX) begin
                    if (pixel_count == 17'(FRAME_PIXELS - 1)) begin
                        pixel_count <= '0;
                        frame_done  <= 1'b1;
                    end else begin
                        pixel_count <= pixel_count + 17'd1;
                    end
                end
            end

            // An index write reports the index it just loaded.
            if (commit && (!ev_valid_q || bus.ev_ready)) begin
                ev_valid_q   <= 1'b1;
                ev_is_data_q <= rs_s;
                ev_index_q   <= rs_s ? index_q : data_s[7:0];
                ev_data_q    <= data_s;
            end else begin
                if (bus.ev_ready) ev_valid_q   <= 1'b0;
                if (commit)       err_overflow <= 1'b1;
            end
        end
    end

    always_comb begin
        read_word = STATUS_WORD;
        if (rs_s) read_word = (index_q == GRAM_INDEX) ? 16'h0000 : regfile[index_q];
    end

    assign read_active = READBACK && (state_d == READ);

    always_ff @(posedge clk) begin
        if (rst) begin
            oe_q   <= 1'b0;
            dout_q <= '0;
        end else begin
            oe_q   <= read_active;
            dout_q <= read_active ? read_word : 16'h0000;
        end
    end

    assign bus.lcd_data_oe  = oe_q;
    assign bus.lcd_data_out = dout_q;
    assign bus.ev_valid     = ev_valid_q;
    assign bus.ev_is_data   = ev_is_data_q;
    assign bus.ev_index     = ev_index_q;
    assign bus.ev_data      = ev_data_q;

endmodule
